// File: rtl/vidc_dma_timing_gen_if.sv
// DMA handshake bundle between the VIDC timing generator and the MEMC.
//   master : VIDC side, drives the active-low requests, samples the acks.
//   slave  : MEMC side, samples the requests, drives the active-low acks.
interface vidc_dma_timing_gen_if;
  logic vidc_nvidrq;
  logic vidc_nsndrq;
  logic vidc_nvidak;
  logic vidc_nsndak;

  modport master (output vidc_nvidrq, output vidc_nsndrq,
                  input  vidc_nvidak, input  vidc_nsndak);
  modport slave  (input  vidc_nvidrq, input  vidc_nsndrq,
                  output vidc_nvidak, output vidc_nsndak);
endinterface

// File: rtl/vidc_dma_timing_gen.sv
// VIDC-side raster timing and DMA request generator.
//   vidc_dma_chan       : one DMA request channel (IDLE/REQ FSM, ack-edge
//                         counter, sticky overrun flag).
//   vidc_dma_timing_gen : x/y raster counters, sync/flyback decode,
//                         frame_start pulse, video and sound channels.
// Top ports:
//   clk, reset_n            pixel clock, async active-low reset
//   run                     1 = raster advances, 0 = stop mode
//   snd_en                  enables the once-per-line sound trigger
//   ovr_clr                 synchronous clear of both overrun flags
//   dma (master)            vidc_nvidrq/nsndrq out, vidc_nvidak/nsndak in
//   vidc_nhs/nvcs/flybk     combinational decodes of x/y
//   frame_start             one-cycle pulse after the x=0,y=0 run cycle
//   vid_overrun/snd_overrun sticky dropped-trigger flags

module vidc_dma_chan #(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run_i,
  input  logic trig_i,
  input  logic ack_n_i,
  input  logic ovr_clr_i,
  output logic rq_n_o,
  output logic ovr_o
);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, rq_q, rq_d, ovr_q, ovr_d, ovr_set, ack_edge;

  assign ack_edge = last_q & ~ack_n_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rq_d    = rq_q;
    ovr_set = 1'b0;
    if (!run_i) begin
      // stop mode abandons any burst in flight
      state_d = S_IDLE;
      cnt_d   = '0;
      rq_d    = 1'b1;
    end else begin
      // request pin trails the FSM state by one edge
      rq_d = (state_q == S_IDLE);
      if (state_q == S_IDLE) begin
        if (trig_i) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end else begin
        ovr_set = trig_i;
        if (ack_edge) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BURST - 1)) state_d = S_IDLE;
        end
      end
    end
    // a set in the same cycle as a clear wins
    ovr_d = ovr_set ? 1'b1 : (ovr_clr_i ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      rq_q    <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= ack_n_i;
      rq_q    <= rq_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rq_n_o = rq_q;
  assign ovr_o  = ovr_q;
endmodule

module vidc_dma_timing_gen #(
  parameter int CTR_W        = 12,
  parameter int HCYC         = 800,
  parameter int HSW          = 95,
  parameter int VCYC         = 525,
  parameter int VSW          = 3,
  parameter int VSTART       = 33,
  parameter int VEND         = 513,
  parameter int VID_PER_LOG2 = 4,
  parameter int VID_BURST    = 4,
  parameter int SND_X        = 2,
  parameter int SND_BURST    = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        run,
  input  logic                        snd_en,
  input  logic                        ovr_clr,
  vidc_dma_timing_gen_if.master       dma,
  output logic                        vidc_nhs,
  output logic                        vidc_nvcs,
  output logic                        vidc_flybk,
  output logic                        frame_start,
  output logic                        vid_overrun,
  output logic                        snd_overrun
);
  localparam logic [CTR_W-1:0] X_LAST   = CTR_W'(HCYC - 1);
  localparam logic [CTR_W-1:0] Y_LAST   = CTR_W'(VCYC - 1);
  localparam logic [CTR_W-1:0] HSW_C    = CTR_W'(HSW);
  localparam logic [CTR_W-1:0] VSW_C    = CTR_W'(VSW);
  localparam logic [CTR_W-1:0] VSTART_C = CTR_W'(VSTART);
  localparam logic [CTR_W-1:0] VEND_C   = CTR_W'(VEND);
  localparam logic [CTR_W-1:0] SNDX_C   = CTR_W'(SND_X);

  logic [CTR_W-1:0] x_q, x_d, y_q, y_d;
  logic             fs_q, in_disp, vid_trig, snd_trig;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (run) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fs_q <= run && (x_q == '0) && (y_q == '0);
    end
  end

  assign in_disp    = (y_q >= VSTART_C) && (y_q < VEND_C);
  assign vidc_nhs   = !(x_q < HSW_C);
  assign vidc_nvcs  = !(y_q < VSW_C);
  assign vidc_flybk = !in_disp;
  assign frame_start = fs_q;

  // video fetches every 2^VID_PER_LOG2 clocks across the active part of display lines
  assign vid_trig = run && in_disp && (x_q >= HSW_C) && (&x_q[VID_PER_LOG2-1:0]);
  assign snd_trig = run && snd_en && (x_q == SNDX_C);

  vidc_dma_chan #(.BURST(VID_BURST)) u_vid (
    .clk(clk), .reset_n(reset_n), .run_i(run), .trig_i(vid_trig),
    .ack_n_i(dma.vidc_nvidak), .ovr_clr_i(ovr_clr),
    .rq_n_o(dma.vidc_nvidrq), .ovr_o(vid_overrun)
  );

  vidc_dma_chan #(.BURST(SND_BURST)) u_snd (
    .clk(clk), .reset_n(reset_n), .run_i(run), .trig_i(snd_trig),
    .ack_n_i(dma.vidc_nsndak), .ovr_clr_i(ovr_clr),
    .rq_n_o(dma.vidc_nsndrq), .ovr_o(snd_overrun)
  );
endmodule

// File: tb/tb_vidc_dma_timing_gen.sv
// Bench for vidc_dma_timing_gen: a raster-position / burst-bookkeeping model,
// per-cycle comparison, directed literal checks, then randomized traffic.
module tb_vidc_dma_timing_gen;
  localparam int HCYC = 40, HSW = 4, VCYC = 10, VSW = 2, VSTART = 3, VEND = 8;
  localparam int VPL = 3, VID_BURST = 2, SND_X = 2, SND_BURST = 1;
  localparam int PER = HCYC * VCYC;

  logic clk = 1'b0;
  logic reset_n, run, snd_en, ovr_clr;
  logic vidc_nhs, vidc_nvcs, vidc_flybk, frame_start, vid_overrun, snd_overrun;

  vidc_dma_timing_gen_if bus ();

  vidc_dma_timing_gen #(
    .CTR_W(12), .HCYC(HCYC), .HSW(HSW), .VCYC(VCYC), .VSW(VSW),
    .VSTART(VSTART), .VEND(VEND), .VID_PER_LOG2(VPL), .VID_BURST(VID_BURST),
    .SND_X(SND_X), .SND_BURST(SND_BURST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .snd_en(snd_en), .ovr_clr(ovr_clr),
    .dma(bus), .vidc_nhs(vidc_nhs), .vidc_nvcs(vidc_nvcs), .vidc_flybk(vidc_flybk),
    .frame_start(frame_start), .vid_overrun(vid_overrun), .snd_overrun(snd_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos is the raster position as a linear count of run cycles in the frame.
  // Each channel tracks whether a burst is outstanding and how many acks remain.
  int m_pos;
  bit m_fs;
  bit m_busy[2], m_last[2], m_rq[2], m_ovr[2];
  int m_left[2];
  int mx, my;
  bit mtrig[2], mak[2], mset;
  int blen[2] = '{VID_BURST, SND_BURST};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pos = 0;
      m_fs  = 0;
      for (int c = 0; c < 2; c++) begin
        m_busy[c] = 0; m_left[c] = 0; m_last[c] = 1; m_rq[c] = 1; m_ovr[c] = 0;
      end
    end else begin
      mx = m_pos % HCYC;
      my = m_pos / HCYC;
      mtrig[0] = run && my >= VSTART && my < VEND && mx >= HSW &&
                 (mx % (1 << VPL)) == (1 << VPL) - 1;
      mtrig[1] = run && snd_en && mx == SND_X;
      mak[0] = bus.vidc_nvidak;
      mak[1] = bus.vidc_nsndak;
      m_fs = run && m_pos == 0;
      for (int c = 0; c < 2; c++) begin
        mset = 0;
        if (!run) begin
          m_busy[c] = 0;
          m_rq[c]   = 1;
        end else begin
          m_rq[c] = !m_busy[c];
          if (m_busy[c]) begin
            if (mtrig[c]) mset = 1;
            if (m_last[c] && !mak[c]) begin
              m_left[c]--;
              if (m_left[c] == 0) m_busy[c] = 0;
            end
          end else if (mtrig[c]) begin
            m_busy[c] = 1;
            m_left[c] = blen[c];
          end
        end
        if (mset) m_ovr[c] = 1;
        else if (ovr_clr) m_ovr[c] = 0;
        m_last[c] = mak[c];
      end
      if (run) m_pos = (m_pos + 1) % PER;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("nhs",   vidc_nhs,   !((m_pos % HCYC) < HSW));
      chk("nvcs",  vidc_nvcs,  !((m_pos / HCYC) < VSW));
      chk("flybk", vidc_flybk, !((m_pos / HCYC) >= VSTART && (m_pos / HCYC) < VEND));
      chk("frame_start", frame_start, m_fs);
      chk("nvidrq", bus.vidc_nvidrq, m_rq[0]);
      chk("nsndrq", bus.vidc_nsndrq, m_rq[1]);
      chk("vid_overrun", vid_overrun, m_ovr[0]);
      chk("snd_overrun", snd_overrun, m_ovr[1]);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_nhs"}, vidc_nhs, 1'b0);
    chk({tag, "_nvcs"}, vidc_nvcs, 1'b0);
    chk({tag, "_flybk"}, vidc_flybk, 1'b1);
    chk({tag, "_fs"}, frame_start, 1'b0);
    chk({tag, "_nvidrq"}, bus.vidc_nvidrq, 1'b1);
    chk({tag, "_nsndrq"}, bus.vidc_nsndrq, 1'b1);
    chk({tag, "_vovr"}, vid_overrun, 1'b0);
    chk({tag, "_sovr"}, snd_overrun, 1'b0);
  endtask

  int nh, fsc;

  initial begin
    reset_n = 1'b1; run = 1'b0; snd_en = 1'b0; ovr_clr = 1'b0;
    bus.vidc_nvidak = 1'b1; bus.vidc_nsndak = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_reset_vals("rst");

    // raster + one video burst; edge k starts from raster position k-1
    @(negedge clk);
    reset_n = 1'b1; run = 1'b1;
    nh = 0; fsc = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k <= 40) nh += (vidc_nhs == 1'b0) ? 1 : 0;
      fsc += frame_start ? 1 : 0;
      if (k == 128) chk("vrq_before_trig", bus.vidc_nvidrq, 1'b1);
      if (k == 129) chk("vrq_low", bus.vidc_nvidrq, 1'b0);
      if (k == 132) chk("vrq_still_low", bus.vidc_nvidrq, 1'b0);
      if (k == 133) chk("vrq_done", bus.vidc_nvidrq, 1'b1);
      if (k == 137) chk("vrq_low2", bus.vidc_nvidrq, 1'b0);
      if (k == 138) chk("vrq_stop", bus.vidc_nvidrq, 1'b1);
      bus.vidc_nvidak = !(k == 129 || k == 131);
      if (k == 137) run = 1'b0;
      if (k == 147) begin run = 1'b1; break; end
    end
    chki("nhs_low_per_line", nh, 4);
    chki("fs_first_frame", fsc, 1);

    // resumed from frozen position 137: triggers at 143, 151, 159
    for (int r = 1; r <= 23; r++) begin
      @(negedge clk);
      if (r == 7)  chk("vrq_resume_hi", bus.vidc_nvidrq, 1'b1);
      if (r == 8)  chk("vrq_resume_lo", bus.vidc_nvidrq, 1'b0);
      if (r == 14) chk("vovr_pre", vid_overrun, 1'b0);
      if (r == 15) chk("vovr_set", vid_overrun, 1'b1);
      if (r == 16) chk("vovr_clr", vid_overrun, 1'b0);
      if (r == 23) chk("vovr_reset", vid_overrun, 1'b1);
      ovr_clr = (r == 15);
    end

    // frame_start cadence over two full frames
    fsc = 0;
    for (int k = 0; k < 2 * PER; k++) begin
      @(negedge clk);
      fsc += frame_start ? 1 : 0;
    end
    chki("fs_two_frames", fsc, 2);

    // async reset mid-cycle, then the sound channel
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("areset");
    @(negedge clk);
    reset_n = 1'b1; run = 1'b1; snd_en = 1'b1; bus.vidc_nvidak = 1'b1;
    for (int s = 1; s <= 44; s++) begin
      @(negedge clk);
      if (s == 3)  chk("srq_before", bus.vidc_nsndrq, 1'b1);
      if (s == 4)  chk("srq_low", bus.vidc_nsndrq, 1'b0);
      if (s == 5)  chk("srq_held", bus.vidc_nsndrq, 1'b0);
      if (s == 6)  chk("srq_done", bus.vidc_nsndrq, 1'b1);
      if (s == 40) chk("srq_idle_ack", bus.vidc_nsndrq, 1'b1);
      if (s == 40) chk("sovr_idle_ack", snd_overrun, 1'b0);
      if (s == 43) chk("srq_line2_hi", bus.vidc_nsndrq, 1'b1);
      if (s == 44) chk("srq_line2_lo", bus.vidc_nsndrq, 1'b0);
      bus.vidc_nsndak = !((s >= 4 && s <= 8) || s == 20);
    end

    // randomized traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i == 2000) begin
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("rnd_reset");
        @(negedge clk);
        reset_n = 1'b1;
      end
      run     = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 99) == 0) snd_en = ~snd_en;
      ovr_clr = ($urandom_range(0, 39) == 0);
      bus.vidc_nvidak = ($urandom_range(0, 2) != 0);
      bus.vidc_nsndak = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
